ram_request_arbiter: RTL and testbench
======================================

# ram_request_arbiter

Single-port RAM arbiter for the dual-core system. It shares the one RAM port among the data-cache and instruction-cache requesters of both cores. Data requests have class priority over instruction fetches, with round-robin within each class and an anti-starvation counter for instruction fetches. It sits between the cache side (icache/dcache per core) and RAM, replacing ad-hoc RAM muxing in the coherence controller.

## Interface
Parameters:
- REQS, 4: requester count; indices 0..1 = dcache core0/core1 (data class), 2..3 = icache core0/core1 (instruction class).
- STARVE_LIMIT, 4: consecutive data grants tolerated while an instruction request is pending.
- TIMEOUT, 64: cycles allowed from grant to ACCESS (only with RAM_ARB_TIMEOUT_EN).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- req_ren  in  REQS  read request per requester.
- req_wen  in  REQS  write request per requester.
- req_addr  in  REQS×32  word address per requester.
- req_store  in  REQS×32  write data per requester.
- req_wait  out  REQS  low only in the completion cycle of that requester's access.
- req_err  out  1  error flag, valid when some req_wait is low.
- req_load  out  32  read data to the granted requester, 0 otherwise.
- grant_id  out  2  index of the current or last grant.
- busy  out  1  high while a grant is held.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t from cpu_types_pkg: FREE, BUSY, ACCESS, ERROR.

## Operation
- Requester i is pending when req_ren[i] | req_wen[i]. If both are set, the access is a write.
- FSM states:
  - IDLE: if any requester is pending, choose a winner, register grant_id, go to GRANT. Otherwise stay in IDLE.
  - GRANT: drive ramaddr = req_addr[g]. Drive ramWEN = req_wen[g], or ramREN otherwise. Drive ramstore = req_store[g] on writes.
    - On ramstate == ACCESS: req_wait[g] = 0. On reads, req_load = ramload. Go to IDLE.
    - On ramstate == ERROR: same as ACCESS, plus req_err = 1.
    - FREE or BUSY: hold.
- Winner selection, evaluated in IDLE only:
  - If any data requester is pending and starve_cnt < STARVE_LIMIT, pick among data requesters.
  - Otherwise, if any instruction requester is pending, pick among instruction requesters.
  - Otherwise, pick among data requesters.
  - Within a class: round-robin. A per-class 1-bit pointer names the preferred index. On a grant, the pointer moves to the other index.
- starve_cnt, 3 bits, saturating:
  - Increments on each data grant issued while an instruction request is pending.
  - Clears on any instruction grant, or when no instruction request is pending in IDLE.
- A requester whose request drops during GRANT is still completed. The RAM access runs, and the wait pulse is issued regardless.
- Requesters must deassert or change their request in the cycle after their wait pulse. A request still held is treated as a new request.

## Timing
- Reset values:
  - Outputs: ramREN/ramWEN = 0, ramaddr/ramstore/req_load = 0, req_wait = all 1, req_err = 0, grant_id = 0, busy = 0.
  - Internal: state IDLE, both pointers = 0, starve_cnt = 0.
- Minimum access is 2 cycles: request seen in IDLE at cycle N; RAM driven from N+1; with ACCESS at N+1, wait goes low in N+1 and the FSM is back in IDLE at N+2.
- Back-to-back grants cost one IDLE cycle. RAM enables are low in every IDLE cycle.
- All RAM outputs are driven from registered grant state. ramaddr is stable for the whole GRANT period.
- busy = 1 exactly in GRANT.
- Reset mid-GRANT: the FSM returns to IDLE immediately, the RAM enables drop asynchronously, and the access is lost with no wait pulse.

## Configuration
- RAM_ARB_TIMEOUT_EN defined:
  - A 7-bit counter clears on entry to GRANT and increments each GRANT cycle without ACCESS or ERROR.
  - When it reaches TIMEOUT-1, the requester gets req_wait = 0 with req_err = 1, RAM enables drop, and the FSM goes to IDLE.
- RAM_ARB_TIMEOUT_EN undefined: no counter; GRANT holds indefinitely; req_err is set only by ramstate ERROR.

## Test plan
- Single read: requester 2 reads 0x100, ACCESS after 3 cycles with ramload = 0xDEADBEEF -> ramREN = 1 and ramaddr = 0x100 for 3 cycles; req_wait[2] low 1 cycle; req_load = 0xDEADBEEF.
- Simultaneous requests 0 and 1, both held, ACCESS every cycle -> grants alternate 0, 1, 0, 1 with an IDLE cycle between each.
- Data 0 and 1 always pending plus instruction 3 pending, STARVE_LIMIT = 4 -> grant_id sequence 0, 1, 0, 1, 3.
- req_ren and req_wen both set on requester 1, addr 0x40, data 0x1234 -> ramWEN = 1, ramREN = 0, ramstore = 0x1234.
- ramstate ERROR on a grant to requester 0 -> req_wait[0] = 0 with req_err = 1; next cycle IDLE.
- With RAM_ARB_TIMEOUT_EN and TIMEOUT = 8, ramstate held BUSY -> req_wait[g] low with req_err = 1 on the 8th GRANT cycle; nRST asserted mid-grant -> all outputs at reset values the same cycle.

Source files
------------

// File: rtl/ram_request_arbiter.sv
// ram_request_arbiter: shares the single RAM port between the two dcaches (data class,
// requesters 0..1) and the two icaches (instruction class, requesters 2..3).
// Data requests win over instruction fetches. Each class rotates round-robin, and a
// saturating counter stops a steady data stream from starving instruction fetches.
// Optional macro RAM_ARB_TIMEOUT_EN: a grant that sees no ACCESS/ERROR within TIMEOUT
// cycles is completed with an error.
// ramstate follows the cpu_types_pkg ramstate_t encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
module ram_request_arbiter #(
    parameter int unsigned REQS         = 4,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [REQS-1:0]        req_ren,
    input  logic [REQS-1:0]        req_wen,
    input  logic [REQS-1:0][31:0]  req_addr,
    input  logic [REQS-1:0][31:0]  req_store,
    output logic [REQS-1:0]        req_wait,
    output logic                   req_err,
    output logic [31:0]            req_load,
    output logic [1:0]             grant_id,
    output logic                   busy,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [31:0]            ramaddr,
    output logic [31:0]            ramstore,
    input  logic [31:0]            ramload,
    input  logic [1:0]             ramstate
);

    localparam logic [1:0] RS_ACCESS  = 2'd2;
    localparam logic [1:0] RS_ERROR   = 2'd3;
    localparam logic [2:0] STARVE_MAX = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  gid_q, gid_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic        dptr_q, dptr_d;
    logic        iptr_q, iptr_d;
    logic [2:0]  starve_q, starve_d;

    logic [REQS-1:0] pend_c;
    logic [1:0]      dpend_c, ipend_c;
    logic            d_any_c, i_any_c;
    logic            d_sel_c, i_sel_c;
    logic            use_instr_c;
    logic [1:0]      win_c;
    logic            start_c;
    logic            acc_c;
    logic            abort_c;
    logic            done_c;

    // Winner selection and grant start/completion conditions
    always_comb begin
        pend_c      = req_ren | req_wen;
        dpend_c     = pend_c[1:0];
        ipend_c     = pend_c[3:2];
        d_any_c     = |dpend_c;
        i_any_c     = |ipend_c;
        d_sel_c     = dpend_c[dptr_q] ? dptr_q : ~dptr_q;
        i_sel_c     = ipend_c[iptr_q] ? iptr_q : ~iptr_q;
        use_instr_c = i_any_c && !(d_any_c && (32'(starve_q) < STARVE_LIMIT));
        win_c       = use_instr_c ? {1'b1, i_sel_c} : {1'b0, d_sel_c};
        start_c     = (state_q == IDLE) && (d_any_c || i_any_c);
        acc_c       = (ramstate == RS_ACCESS) || (ramstate == RS_ERROR);
        done_c      = (state_q == GRANT) && (acc_c || abort_c);
    end

`ifdef RAM_ARB_TIMEOUT_EN
    localparam logic [6:0] TMR_LAST = 7'(TIMEOUT - 1);

    logic [6:0] tmr_q, tmr_d;

    // Grant watchdog: restarts with each grant, counts grant cycles without a RAM response
    always_comb begin
        tmr_d = tmr_q;
        if (start_c) begin
            tmr_d = '0;
        end else if ((state_q == GRANT) && !done_c) begin
            tmr_d = tmr_q + 7'd1;
        end
    end

    // Watchdog register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign abort_c = (state_q == GRANT) && !acc_c && (tmr_q == TMR_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = ^7'(TIMEOUT);
    assign abort_c        = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_c) state_d = GRANT;
            GRANT: if (done_c)  state_d = IDLE;
        endcase
    end

    // Grant capture, round-robin pointers and starvation counter
    always_comb begin
        gid_d    = gid_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        store_d  = store_q;
        dptr_d   = dptr_q;
        iptr_d   = iptr_q;
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (!i_any_c) begin
                starve_d = '0;
            end
            if (start_c) begin
                gid_d   = win_c;
                wr_d    = req_wen[win_c];
                addr_d  = req_addr[win_c];
                store_d = req_wen[win_c] ? req_store[win_c] : '0;
                if (use_instr_c) begin
                    iptr_d   = ~i_sel_c;
                    starve_d = '0;
                end else begin
                    dptr_d = ~d_sel_c;
                    if (i_any_c && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + 3'd1;
                    end
                end
            end
        end
    end

    // Grant state registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            gid_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            store_q  <= '0;
            dptr_q   <= 1'b0;
            iptr_q   <= 1'b0;
            starve_q <= '0;
        end else begin
            gid_q    <= gid_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            dptr_q   <= dptr_d;
            iptr_q   <= iptr_d;
            starve_q <= starve_d;
        end
    end

    // Outputs: RAM enables from the held grant, completion pulse from the RAM response
    always_comb begin
        busy     = (state_q == GRANT);
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        req_wait = '1;
        req_err  = 1'b0;
        req_load = '0;
        if (state_q == GRANT) begin
            ramWEN = wr_q && !abort_c;
            ramREN = !wr_q && !abort_c;
            if (done_c) begin
                req_wait[gid_q] = 1'b0;
                req_err         = (ramstate == RS_ERROR) || abort_c;
                if (!wr_q && acc_c) begin
                    req_load = ramload;
                end
            end
        end
    end

    assign grant_id = gid_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

endmodule

// File: tb/tb_ram_request_arbiter.sv
// Bench for ram_request_arbiter: directed scenarios followed by random requester traffic,
// all compared cycle by cycle against a transaction-level model of the arbitration rules.
module tb_ram_request_arbiter;

    localparam int unsigned SL = 4;
    localparam int unsigned TO = 8;

    logic              CLK;
    logic              nRST;
    logic [3:0]        req_ren, req_wen, req_wait;
    logic [3:0][31:0]  req_addr, req_store;
    logic              req_err, busy, ramREN, ramWEN;
    logic [31:0]       req_load, ramaddr, ramstore, ramload;
    logic [1:0]        grant_id, ramstate;

    ram_request_arbiter #(.REQS(4), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_store(req_store),
        .req_wait(req_wait), .req_err(req_err), .req_load(req_load),
        .grant_id(grant_id), .busy(busy),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    bit          m_grant;
    int          m_gid, dptr, iptr, starve, m_tmr;
    bit          m_wr;
    logic [31:0] m_addr, m_store;
    bit          act[4];
    bit          prev_busy;
    int          gseq[$];

    // last observed outputs
    bit          obs_busy, obs_ren, obs_wen, obs_err;
    logic [3:0]  obs_wait;
    logic [31:0] obs_load, obs_addr, obs_store;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_grant = 0; m_gid = 0; dptr = 0; iptr = 0; starve = 0; m_tmr = 0;
        m_wr = 0; m_addr = '0; m_store = '0; prev_busy = 0;
        for (int i = 0; i < 4; i++) act[i] = 0;
    endtask

    task automatic clear_reqs();
        req_ren = '0; req_wen = '0; req_addr = '0; req_store = '0;
        ramstate = 2'd0; ramload = '0;
    endtask

    task automatic check_reset();
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_ramREN",   32'(ramREN),   32'd0);
        check("rst_ramWEN",   32'(ramWEN),   32'd0);
        check("rst_ramaddr",  ramaddr,       32'd0);
        check("rst_ramstore", ramstore,      32'd0);
        check("rst_req_load", req_load,      32'd0);
        check("rst_req_wait", 32'(req_wait), 32'hF);
        check("rst_req_err",  32'(req_err),  32'd0);
    endtask

    // One clock: compare outputs with the model at the falling edge, then advance the model.
    task automatic step();
        logic [3:0] pend, ew;
        bit acc, to_hit, done;
        int w, nd, ni;
        @(negedge CLK);
        pend   = req_ren | req_wen;
        acc    = (ramstate == 2'd2) || (ramstate == 2'd3);
        to_hit = 0;
`ifdef RAM_ARB_TIMEOUT_EN
        to_hit = m_grant && !acc && (m_tmr == int'(TO) - 1);
`endif
        done = m_grant && (acc || to_hit);
        ew = 4'hF;
        if (done) ew[m_gid] = 1'b0;
        check("busy",     32'(busy),     32'(m_grant));
        check("grant_id", 32'(grant_id), 32'(m_gid));
        check("req_wait", 32'(req_wait), 32'(ew));
        check("req_err",  32'(req_err),  32'(done && ((ramstate == 2'd3) || to_hit)));
        check("req_load", req_load,      (done && acc && !m_wr) ? ramload : 32'd0);
        check("ramREN",   32'(ramREN),   32'(m_grant && !m_wr && !to_hit));
        check("ramWEN",   32'(ramWEN),   32'(m_grant && m_wr && !to_hit));
        if (m_grant) check("ramaddr", ramaddr, m_addr);
        if (m_grant && m_wr) check("ramstore", ramstore, m_store);
        obs_busy = busy; obs_ren = ramREN; obs_wen = ramWEN; obs_err = req_err;
        obs_wait = req_wait; obs_load = req_load; obs_addr = ramaddr; obs_store = ramstore;
        if (busy && !prev_busy) gseq.push_back(int'(grant_id));
        prev_busy = busy;
        if (done) act[m_gid] = 0;
        if (!m_grant) begin
            nd = int'(pend[0]) + int'(pend[1]);
            ni = int'(pend[2]) + int'(pend[3]);
            if (nd > 0 && starve < int'(SL)) begin
                w = pend[dptr] ? dptr : 1 - dptr;
                dptr = 1 - w;
                starve = (ni > 0) ? ((starve < 7) ? starve + 1 : 7) : 0;
            end else if (ni > 0) begin
                w = pend[2 + iptr] ? 2 + iptr : 3 - iptr;
                iptr = 3 - w;
                starve = 0;
            end else begin
                w = -1;
                starve = 0;
            end
            if (w >= 0) begin
                m_grant = 1; m_gid = w; m_wr = req_wen[w];
                m_addr = req_addr[w]; m_store = req_store[w]; m_tmr = 0;
            end
        end else if (done) begin
            m_grant = 0;
        end else begin
            m_tmr++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_random();
        int k;
        for (int i = 0; i < 4; i++) begin
            if (!act[i]) begin
                if ($urandom_range(0, 2) != 0) begin
                    act[i] = 1;
                    k = $urandom_range(0, 2);
                    req_ren[i]   = (k != 1);
                    req_wen[i]   = (k != 0);
                    req_addr[i]  = $urandom;
                    req_store[i] = $urandom;
                end else begin
                    req_ren[i] = 1'b0;
                    req_wen[i] = 1'b0;
                end
            end else if (m_grant && m_gid == i && $urandom_range(0, 9) == 0) begin
                req_ren[i] = 1'b0;
                req_wen[i] = 1'b0;
                act[i]     = 0;
            end
        end
        ramload = $urandom;
        if (m_grant) begin
            k = $urandom_range(0, 9);
            ramstate = (k < 4) ? 2'd2 : (k == 4) ? 2'd3 : 2'(k % 2);
        end else begin
            ramstate = 2'($urandom_range(0, 3));
        end
    endtask

    initial begin
        int n_ren, n_pulse, idx;
        logic [31:0] load_seen;
        bit err_seen;
        nRST = 1'b0;
        clear_reqs();
        reset_model();
        #12;
        check_reset();
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK);
        #1;

        // single read by requester 2, ACCESS on the third grant cycle
        req_ren[2] = 1'b1; req_addr[2] = 32'h100;
        step();
        n_ren = 0; n_pulse = 0; load_seen = '0;
        for (int c = 0; c < 3; c++) begin
            ramstate = (c == 2) ? 2'd2 : 2'd1;
            ramload  = 32'hDEADBEEF;
            step();
            if (obs_ren && obs_addr == 32'h100) n_ren++;
            if (!obs_wait[2]) begin n_pulse++; load_seen = obs_load; end
        end
        check("rd_ren_cycles", 32'(n_ren), 32'd3);
        check("rd_pulses", 32'(n_pulse), 32'd1);
        check("rd_load", load_seen, 32'hDEADBEEF);
        clear_reqs();
        step();

        // two data requesters held, ACCESS every cycle
        req_ren[0] = 1'b1; req_ren[1] = 1'b1; ramstate = 2'd2;
        gseq.delete();
        repeat (8) step();
        check("rr_count", 32'(gseq.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            check("rr_seq", 32'((gseq.size() > k) ? gseq[k] : -1), 32'(k % 2));

        // instruction requester 3 joins the data stream
        req_ren[3] = 1'b1;
        gseq.delete();
        repeat (10) step();
        for (int k = 0; k < 5; k++) begin
            idx = (k == 4) ? 3 : k % 2;
            check("starve_seq", 32'((gseq.size() > k) ? gseq[k] : -1), 32'(idx));
        end
        clear_reqs();
        step();

        // read and write both set: treated as a write
        req_ren[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = 32'h40; req_store[1] = 32'h1234;
        ramstate = 2'd1;
        step();
        ramstate = 2'd2;
        step();
        check("rw_wen", 32'(obs_wen), 32'd1);
        check("rw_ren", 32'(obs_ren), 32'd0);
        check("rw_store", obs_store, 32'h1234);
        check("rw_addr", obs_addr, 32'h40);
        clear_reqs();
        step();

        // ERROR response on a grant to requester 0
        req_ren[0] = 1'b1; req_addr[0] = 32'h200;
        step();
        ramstate = 2'd3;
        step();
        check("err_wait", 32'(obs_wait), 32'hE);
        check("err_flag", 32'(obs_err), 32'd1);
        clear_reqs();
        step();
        check("err_idle", 32'(obs_busy), 32'd0);

`ifdef RAM_ARB_TIMEOUT_EN
        // RAM never answers: watchdog completes the access with an error
        req_ren[2] = 1'b1; req_addr[2] = 32'h300; ramstate = 2'd1;
        step();
        idx = 0; err_seen = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (!obs_wait[2]) begin idx = c; err_seen = obs_err; break; end
        end
        check("to_cycle", 32'(idx), 32'(TO));
        check("to_err", 32'(err_seen), 32'd1);
        clear_reqs();
        step();
`endif

        // reset asserted in the middle of a write grant
        req_wen[0] = 1'b1; req_addr[0] = 32'h80; req_store[0] = 32'h55; ramstate = 2'd1;
        step();
        step();
        check("mid_busy", 32'(obs_busy), 32'd1);
        #2 nRST = 1'b0;
        #1 check_reset();
        reset_model();
        clear_reqs();
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK);
        #1;

        // random traffic
        repeat (3000) begin
            drive_random();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
